// File: rtl/product_collector.sv
// Collects multiplier products into a small FIFO drained by valid/ready, and keeps
// saturating statistics (sum, count, drops, overflow) since the last clear.
module product_collector #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [15:0]      Product_In,
  input  logic             Product_Valid_In,
  input  logic             Clear,
  input  logic             Out_Ready,
  output logic [15:0]      Out_Data,
  output logic             Out_Valid,
  output logic             Full,
  output logic [ACC_W-1:0] Acc_Sum,
  output logic [CNT_W-1:0] Acc_Count,
  output logic [CNT_W-1:0] Drop_Count,
  output logic             Overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]      mem_q [DEPTH];
  logic [15:0]      mem_d [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ACC_W-1:0] acc_sum_q, acc_sum_d;
  logic [CNT_W-1:0] acc_count_q, acc_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             overflow_q, overflow_d;

  logic             empty, full, pop, push;
  logic [ACC_W:0]   sum_ext;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign pop     = ~empty & Out_Ready;
  assign push    = Product_Valid_In & (~full | pop);
  // One extra bit catches the carry that signals saturation.
  assign sum_ext = {1'b0, acc_sum_q} + {{(ACC_W + 1 - 16){1'b0}}, Product_In};

  always_comb begin
    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    acc_sum_d    = acc_sum_q;
    acc_count_d  = acc_count_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    if (Clear) begin
      wptr_d       = '0;
      rptr_d       = '0;
      acc_sum_d    = '0;
      acc_count_d  = '0;
      drop_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      if (pop) begin
        rptr_d = rptr_q + (AW + 1)'(1);
      end
      if (push) begin
        mem_d[wptr_q[AW-1:0]] = Product_In;
        wptr_d                = wptr_q + (AW + 1)'(1);
      end
      if (Product_Valid_In && !push && drop_count_q != '1) begin
        drop_count_d = drop_count_q + CNT_W'(1);
      end
      if (Product_Valid_In) begin
        if (acc_count_q != '1) begin
          acc_count_d = acc_count_q + CNT_W'(1);
        end
        if (sum_ext[ACC_W]) begin
          acc_sum_d  = '1;
          overflow_d = 1'b1;
        end else begin
          acc_sum_d = sum_ext[ACC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_q        <= '{default: '0};
      wptr_q       <= '0;
      rptr_q       <= '0;
      acc_sum_q    <= '0;
      acc_count_q  <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      acc_sum_q    <= acc_sum_d;
      acc_count_q  <= acc_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign Out_Valid  = ~empty;
  assign Out_Data   = empty ? 16'h0000 : mem_q[rptr_q[AW-1:0]];
  assign Full       = full;
  assign Acc_Sum    = acc_sum_q;
  assign Acc_Count  = acc_count_q;
  assign Drop_Count = drop_count_q;
  assign Overflow   = overflow_q;

endmodule

// File: tb/tb_product_collector.sv
// Bench for product_collector: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_product_collector;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned CNT_W = 8;
  localparam longint SUM_MAX = (longint'(1) << ACC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [15:0]      Product_In = '0;
  logic             Product_Valid_In = 1'b0;
  logic             Clear = 1'b0;
  logic             Out_Ready = 1'b0;
  logic [15:0]      Out_Data;
  logic             Out_Valid;
  logic             Full;
  logic [ACC_W-1:0] Acc_Sum;
  logic [CNT_W-1:0] Acc_Count;
  logic [CNT_W-1:0] Drop_Count;
  logic             Overflow;

  product_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .Product_In(Product_In), .Product_Valid_In(Product_Valid_In),
    .Clear(Clear), .Out_Ready(Out_Ready), .Out_Data(Out_Data), .Out_Valid(Out_Valid),
    .Full(Full), .Acc_Sum(Acc_Sum), .Acc_Count(Acc_Count), .Drop_Count(Drop_Count),
    .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: plain queue plus integer statistics.
  int     mq[$];
  longint msum;
  int     mcnt, mdrop;
  bit     movf;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        ev;
    logic [15:0] ed;
    logic        ef;
    logic [23:0] es;
    logic [7:0]  ec;
    logic [7:0]  edr;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    msum = 0; mcnt = 0; mdrop = 0; movf = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit r, input bit c);
    bit popped, was_full;
    if (c) begin
      model_reset();
      return;
    end
    popped   = (mq.size() > 0) && r;
    was_full = (mq.size() == DEPTH);
    if (popped) void'(mq.pop_front());
    if (v) begin
      if (!was_full || popped) mq.push_back(d);
      else if (mdrop < CNT_MAX) mdrop++;
      if (mcnt < CNT_MAX) mcnt++;
      msum += d;
      if (msum > SUM_MAX) begin
        msum = SUM_MAX;
        movf = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, Out_Valid, mq.size() > 0);
    chk({tag, ".data"}, Out_Data, (mq.size() > 0) ? mq[0] : 0);
    chk({tag, ".full"}, Full, mq.size() == DEPTH);
    chk({tag, ".sum"}, Acc_Sum, msum);
    chk({tag, ".count"}, Acc_Count, mcnt);
    chk({tag, ".drop"}, Drop_Count, mdrop);
    chk({tag, ".ovf"}, Overflow, movf);
  endtask

  // Drive one cycle, clock it, then compare against the model 1 time unit after the edge.
  task automatic apply(input bit v, input logic [15:0] d, input bit r, input bit c,
                       input string tag);
    Product_Valid_In = v;
    Product_In       = d;
    Out_Ready        = r;
    Clear            = c;
    @(posedge CLK);
    #1;
    model_step(v, int'(d), r, c);
    Product_Valid_In = 1'b0;
    Clear            = 1'b0;
    check_model(tag);
  endtask

  task automatic add(input logic v, input logic [15:0] d, input logic r, input logic ev,
                     input logic [15:0] ed, input logic ef, input logic [23:0] es,
                     input logic [7:0] ec, input logic [7:0] edr);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.ev = ev; t.ed = ed; t.ef = ef;
    t.es = es; t.ec = ec; t.edr = edr;
    vecs.push_back(t);
  endtask

  initial begin
    // Fill/backpressure, then full with simultaneous push and pop.
    add(1, 1,  0, 1, 1,  0, 1,   1,  0);
    add(1, 2,  0, 1, 1,  0, 3,   2,  0);
    add(1, 3,  0, 1, 1,  0, 6,   3,  0);
    add(1, 4,  0, 1, 1,  1, 10,  4,  0);
    add(1, 5,  0, 1, 1,  1, 15,  5,  1);
    add(0, 0,  1, 1, 2,  0, 15,  5,  1);
    add(0, 0,  1, 1, 3,  0, 15,  5,  1);
    add(0, 0,  1, 1, 4,  0, 15,  5,  1);
    add(0, 0,  1, 0, 0,  0, 15,  5,  1);
    add(1, 10, 0, 1, 10, 0, 25,  6,  1);
    add(1, 20, 0, 1, 10, 0, 45,  7,  1);
    add(1, 30, 0, 1, 10, 0, 75,  8,  1);
    add(1, 40, 0, 1, 10, 1, 115, 9,  1);
    add(1, 50, 1, 1, 20, 1, 165, 10, 1);
    add(0, 0,  1, 1, 30, 0, 165, 10, 1);
    add(0, 0,  1, 1, 40, 0, 165, 10, 1);
    add(0, 0,  1, 1, 50, 0, 165, 10, 1);
    add(0, 0,  1, 0, 0,  0, 165, 10, 1);

    model_reset();
    // Reset state.
    #12;
    check_model("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Single product with one-cycle latency.
    apply(1, 16'h0F1E, 1, 0, "single");
    chk("single.data_lit", Out_Data, 16'h0F1E);
    chk("single.sum_lit", Acc_Sum, 24'h000F1E);
    apply(0, 0, 1, 0, "single_drain");
    chk("single.gone", Out_Valid, 0);

    // Directed table, starting from a cleared block.
    apply(0, 0, 0, 1, "pre_table_clear");
    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].d, vecs[i].r, 0, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.valid", i), Out_Valid, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("tbl%0d.data", i), Out_Data, vecs[i].ed);
      chk($sformatf("tbl%0d.full", i), Full, vecs[i].ef);
      chk($sformatf("tbl%0d.sum", i), Acc_Sum, vecs[i].es);
      chk($sformatf("tbl%0d.count", i), Acc_Count, vecs[i].ec);
      chk($sformatf("tbl%0d.drop", i), Drop_Count, vecs[i].edr);
    end

    // Accumulator saturation.
    apply(0, 0, 0, 1, "sat_clear");
    for (int i = 0; i < 256; i++) apply(1, 16'hFFFF, 1, 0, "sat");
    chk("sat256.sum", Acc_Sum, 24'hFFFF00);
    chk("sat256.ovf", Overflow, 0);
    chk("sat256.count", Acc_Count, 8'hFF);
    apply(1, 16'hFFFF, 1, 0, "sat257");
    chk("sat257.sum", Acc_Sum, 24'hFFFFFF);
    chk("sat257.ovf", Overflow, 1);
    apply(1, 16'h0001, 1, 0, "sat_hold");
    chk("sat_hold.ovf", Overflow, 1);

    // Clear priority over a simultaneous product and pop.
    apply(0, 0, 0, 1, "cp_clear");
    apply(1, 16'h0011, 0, 0, "cp_a");
    apply(1, 16'h0022, 0, 0, "cp_b");
    apply(1, 16'h1234, 1, 1, "cp_clr");
    chk("cp.valid", Out_Valid, 0);
    chk("cp.sum", Acc_Sum, 0);
    chk("cp.count", Acc_Count, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 0, "cp_after");
      chk("cp.no1234", Out_Data != 16'h1234, 1);
    end

    // Asynchronous reset mid-operation.
    apply(1, 16'h0101, 0, 0, "rm_a");
    apply(1, 16'h0202, 0, 0, "rm_b");
    apply(1, 16'h0303, 0, 0, "rm_c");
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_model("rst_mid");
    @(negedge CLK);
    RST_N = 1'b1;
    apply(1, 16'hBEEF, 0, 0, "rm_new");
    chk("rm_new.data_lit", Out_Data, 16'hBEEF);

    // Randomized traffic.
    apply(0, 0, 0, 1, "rnd_clear");
    for (int i = 0; i < 3000; i++) begin
      bit          v, r, c;
      logic [15:0] d;
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 999) < 3);
      d = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 15))
                                      : 16'($urandom);
      apply(v, d, r, c, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
